// File: rtl/moore_seq_det_pkg.sv
// Shared constants and elaboration-time helpers for moore_seq_det.
// Holds the KMP transition functions, parameter range checks and ST_W derivation.
package moore_seq_det_pkg;

  localparam int MIN_PAT_LEN = 2;
  localparam int MAX_PAT_LEN = 16;
  localparam int MIN_CNT_W   = 1;
  localparam int MAX_CNT_W   = 32;

  typedef enum logic {
    MODE_NOVL = 1'b0,
    MODE_OVL  = 1'b1
  } ovl_mode_e;

  function automatic int st_w(input int len);
    return $clog2(len + 1);
  endfunction

  function automatic bit pat_len_ok(input int len);
    return (len >= MIN_PAT_LEN) && (len <= MAX_PAT_LEN);
  endfunction

  function automatic bit cnt_w_ok(input int w);
    return (w >= MIN_CNT_W) && (w <= MAX_CNT_W);
  endfunction

  // i-th pattern bit in arrival order (0 = first received).
  function automatic logic rx_bit(
    input logic [MAX_PAT_LEN-1:0] pat,
    input int                     len,
    input int                     i
  );
    return pat[len-1-i];
  endfunction

  function automatic int next_on_match(input int k);
    return k + 1;
  endfunction

  // Longest proper suffix of (first k pattern bits + b)
  // that is also a pattern prefix.
  function automatic int fail_target(
    input int                     k,
    input logic                   b,
    input logic [MAX_PAT_LEN-1:0] pat,
    input int                     len
  );
    int   res;
    int   idx;
    bit   ok;
    logic c;
    res = 0;
    for (int m = 1; m <= k; m++) begin
      ok = 1'b1;
      for (int j = 0; j < m; j++) begin
        idx = k + 1 - m + j;
        c = (idx < k) ? rx_bit(pat, len, idx) : b;
        if (c != rx_bit(pat, len, j))
          ok = 1'b0;
      end
      if (ok)
        res = m;
    end
    return res;
  endfunction

  // Longest proper border of the whole pattern.
  function automatic int border(
    input logic [MAX_PAT_LEN-1:0] pat,
    input int                     len
  );
    int res;
    bit ok;
    res = 0;
    for (int m = 1; m < len; m++) begin
      ok = 1'b1;
      for (int j = 0; j < m; j++) begin
        if (rx_bit(pat, len, j) != rx_bit(pat, len, len - m + j))
          ok = 1'b0;
      end
      if (ok)
        res = m;
    end
    return res;
  endfunction

  // Full transition from a partial-match state k < len.
  function automatic int step_target(
    input int                     k,
    input logic                   b,
    input logic [MAX_PAT_LEN-1:0] pat,
    input int                     len
  );
    if (b == rx_bit(pat, len, k))
      return next_on_match(k);
    return fail_target(k, b, pat, len);
  endfunction

endpackage

// File: rtl/moore_seq_det_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Ports: clk, rst (async active-low), inc, clr, count[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != MAX))
      count <= count + W'(1);
  end

endmodule

// File: rtl/moore_seq_det.sv
// Parametrised Moore serial-pattern detector with KMP failure transitions.
// Ports: clk, rst (async active-low), x data, z qualifier, ovl overlap mode,
//   y registered match flag, state_o matched-bit count;
//   with MOORE_SEQ_DET_CNT_EN also cnt_clr and saturating match_cnt.
module moore_seq_det
  import moore_seq_det_pkg::*;
#(
  parameter int               PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8,
  localparam int              ST_W    = st_w(PAT_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             z,
  input  logic             ovl,
`ifdef MOORE_SEQ_DET_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic             y,
  output logic [ST_W-1:0]  state_o
);

  if (!pat_len_ok(PAT_LEN)) begin : g_bad_len
    $error("moore_seq_det: PAT_LEN must be 2..16");
  end

  if (!cnt_w_ok(CNT_W)) begin : g_bad_cnt
    $error("moore_seq_det: CNT_W must be 1..32");
  end

  localparam logic [MAX_PAT_LEN-1:0] PAT16 =
    MAX_PAT_LEN'(PATTERN);
  localparam int BRD = border(PAT16, PAT_LEN);
  localparam logic [ST_W-1:0] LAST   = ST_W'(PAT_LEN);
  localparam logic [ST_W-1:0] BRD_ST = ST_W'(BRD);
  localparam int TAB_N = 2 ** ST_W;

  // Constant transition tables, one entry per partial state.
  // Padded to a power of two so the state indexes them directly.
  logic [ST_W-1:0] tgt0 [TAB_N];
  logic [ST_W-1:0] tgt1 [TAB_N];

  for (genvar k = 0; k < TAB_N; k++) begin : g_tab
    if (k < PAT_LEN) begin : g_live
      assign tgt0[k] =
        ST_W'(step_target(k, 1'b0, PAT16, PAT_LEN));
      assign tgt1[k] =
        ST_W'(step_target(k, 1'b1, PAT16, PAT_LEN));
    end else begin : g_pad
      assign tgt0[k] = '0;
      assign tgt1[k] = '0;
    end
  end

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] nxt;
  logic [ST_W-1:0] src;
  logic            y_q;
  ovl_mode_e       mode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= '0;
      y_q   <= 1'b0;
    end else begin
      state <= nxt;
      y_q   <= (nxt == LAST);
    end
  end

  // A full match re-enters the partial-state table either at the
  // pattern border (overlap) or at S0 (non-overlap).
  always_comb begin
    mode = ovl_mode_e'(ovl);
    src  = state;
    nxt  = state;
    if (state == LAST)
      src = (mode == MODE_OVL) ? BRD_ST : '0;
    unique case (1'b1)
      !z:       nxt = state;
      z && x:   nxt = tgt1[src];
      z && !x:  nxt = tgt0[src];
      default:  nxt = state;
    endcase
  end

  assign y       = y_q;
  assign state_o = state;

`ifdef MOORE_SEQ_DET_CNT_EN
  logic inc;
  assign inc = z && (nxt == LAST);

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc),
    .clr  (cnt_clr),
    .count(match_cnt)
  );
`endif

endmodule

// File: tb/tb_moore_seq_det.sv
// Scoreboard bench for moore_seq_det: three pattern configs share one stream.
// Reference model tracks the recent-bit window and longest matching suffix.
module tb_moore_seq_det;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x = 1'b0;
  logic z = 1'b0;
  logic ovl = 1'b0;
  logic cnt_clr = 1'b0;

  logic [2:0] st_a, st_b, st_c;
  logic       y_a, y_b, y_c;
`ifdef MOORE_SEQ_DET_CNT_EN
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [2:0] cnt_c;
`endif

  always #5 clk = ~clk;

  moore_seq_det #(
    .PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)
  ) dut_a (
    .clk(clk), .rst(rst), .x(x), .z(z), .ovl(ovl),
`ifdef MOORE_SEQ_DET_CNT_EN
    .cnt_clr(cnt_clr), .match_cnt(cnt_a),
`endif
    .y(y_a), .state_o(st_a)
  );

  moore_seq_det #(
    .PAT_LEN(4), .PATTERN(4'b1111), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .x(x), .z(z), .ovl(ovl),
`ifdef MOORE_SEQ_DET_CNT_EN
    .cnt_clr(cnt_clr), .match_cnt(cnt_b),
`endif
    .y(y_b), .state_o(st_b)
  );

  moore_seq_det #(
    .PAT_LEN(6), .PATTERN(6'b110110), .CNT_W(3)
  ) dut_c (
    .clk(clk), .rst(rst), .x(x), .z(z), .ovl(ovl),
`ifdef MOORE_SEQ_DET_CNT_EN
    .cnt_clr(cnt_clr), .match_cnt(cnt_c),
`endif
    .y(y_c), .state_o(st_c)
  );

  typedef struct packed {
    logic [2:0][3:0] st;
    logic [2:0]      y;
    logic [2:0][7:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_err = 0;

  int          m_len [3] = '{4, 4, 6};
  logic [15:0] m_pat [3] = '{16'h000B, 16'h000F, 16'h0036};
  int          m_max [3] = '{255, 3, 7};
  logic [15:0] m_hv  [3];
  int          m_hl  [3];
  int          m_st  [3];
  int          m_cnt [3];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Longest suffix of the received window that equals a pattern prefix.
  function automatic int longest(input logic [15:0] hv, input int hl,
                                 input logic [15:0] pat, input int len);
    int res;
    int mk;
    res = 0;
    for (int m = 1; m <= hl; m++) begin
      mk = (1 << m) - 1;
      if ((int'(hv) & mk) == ((int'(pat) >> (len - m)) & mk))
        res = m;
    end
    return res;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_hv[i] = '0;
      m_hl[i] = 0;
      m_st[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic model_step(input bit xi, input bit zi,
                            input bit oi, input bit ci);
    for (int i = 0; i < 3; i++) begin
      if (zi) begin
        if (m_st[i] == m_len[i] && !oi) begin
          m_hv[i] = '0;
          m_hl[i] = 0;
        end
        m_hv[i] = {m_hv[i][14:0], xi};
        if (m_hl[i] < m_len[i])
          m_hl[i]++;
        m_st[i] = longest(m_hv[i], m_hl[i], m_pat[i], m_len[i]);
      end
      if (ci)
        m_cnt[i] = 0;
      else if (zi && m_st[i] == m_len[i] && m_cnt[i] < m_max[i])
        m_cnt[i]++;
    end
  endtask

  task automatic drv(input bit xi, input bit zi,
                     input bit oi, input bit ci);
    exp_t e;
    @(negedge clk);
    x = xi;
    z = zi;
    ovl = oi;
    cnt_clr = ci;
    model_step(xi, zi, oi, ci);
    for (int i = 0; i < 3; i++) begin
      e.st[i]  = 4'(m_st[i]);
      e.y[i]   = (m_st[i] == m_len[i]);
      e.cnt[i] = 8'(m_cnt[i]);
    end
    q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    x = 1'b0;
    z = 1'b0;
    cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("state_a", int'(st_a), int'(e.st[0]));
        chk("state_b", int'(st_b), int'(e.st[1]));
        chk("state_c", int'(st_c), int'(e.st[2]));
        chk("y_a", int'(y_a), int'(e.y[0]));
        chk("y_b", int'(y_b), int'(e.y[1]));
        chk("y_c", int'(y_c), int'(e.y[2]));
`ifdef MOORE_SEQ_DET_CNT_EN
        chk("cnt_a", int'(cnt_a), int'(e.cnt[0]));
        chk("cnt_b", int'(cnt_b), int'(e.cnt[1]));
        chk("cnt_c", int'(cnt_c), int'(e.cnt[2]));
`endif
      end
    end
  end

  initial begin
    bit ov_stream [7];
    bit ro;
    ov_stream = '{1, 0, 1, 1, 0, 1, 1};
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_state_a", int'(st_a), 0);
    chk("rst_y_a", int'(y_a), 0);
    chk("rst_state_c", int'(st_c), 0);
    rst = 1'b1;

    // overlapping 1011 stream
    for (int i = 0; i < 7; i++) begin
      drv(ov_stream[i], 1'b1, 1'b1, 1'b0);
      settle();
      if (i == 3) chk("ovl_b4_state", int'(st_a), 4);
      if (i == 4) chk("ovl_b5_state", int'(st_a), 2);
      if (i == 6) chk("ovl_b7_y", int'(y_a), 1);
    end
`ifdef MOORE_SEQ_DET_CNT_EN
    chk("ovl_cnt", int'(cnt_a), 2);
`endif

    // non-overlapping
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drv(ov_stream[i], 1'b1, 1'b0, 1'b0);
      settle();
      if (i == 6) chk("novl_b7_state", int'(st_a), 1);
    end
`ifdef MOORE_SEQ_DET_CNT_EN
    chk("novl_cnt", int'(cnt_a), 1);
`endif

    // qualifier hold, failure target, async reset mid-pattern
    apply_reset();
    drv(1, 1, 1, 0);
    drv(0, 1, 1, 0);
    drv(1, 1, 1, 0);
    for (int i = 0; i < 3; i++)
      drv(i[0], 0, 1, 0);
    settle();
    chk("hold_state", int'(st_a), 3);
    drv(0, 1, 1, 0);
    settle();
    chk("fail_1010", int'(st_a), 2);
    drv(1, 1, 1, 0);
    settle();
    chk("pre_rst_state", int'(st_a), 3);
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_state", int'(st_a), 0);
    chk("async_rst_y", int'(y_a), 0);
`ifdef MOORE_SEQ_DET_CNT_EN
    chk("async_rst_cnt", int'(cnt_a), 0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // self-overlapping 1111
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drv(1, 1, 1, 0);
      settle();
      chk("ones_ovl_y", int'(y_b), (i >= 3) ? 1 : 0);
    end
`ifdef MOORE_SEQ_DET_CNT_EN
    chk("ones_ovl_cnt", int'(cnt_b), 3);
`endif
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drv(1, 1, 0, 0);
      settle();
      chk("ones_novl_y", int'(y_b), (i == 3) ? 1 : 0);
    end

    // saturation and clear-beats-increment
    apply_reset();
    for (int i = 0; i < 8; i++)
      drv(1, 1, 1, 0);
    settle();
`ifdef MOORE_SEQ_DET_CNT_EN
    chk("sat_cnt", int'(cnt_b), 3);
`endif
    drv(1, 1, 1, 1);
    settle();
`ifdef MOORE_SEQ_DET_CNT_EN
    chk("clr_wins", int'(cnt_b), 0);
`endif
    chk("clr_match_y", int'(y_b), 1);

    // randomized traffic
    ro = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0)
        ro = !ro;
      drv(1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) != 0),
          ro,
          ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 499) == 0)
        apply_reset();
    end

    for (int i = 0; i < 10 && q.size() != 0; i++)
      @(posedge clk);
    #2;
    if (q.size() != 0)
      chk("drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/moore_seq_det.md
Name: moore_seq_det

Overview:
Parametrised Moore serial-pattern detector. Next generation of the team's fixed 4-state x/z Moore FSMs. Pattern length and value are generics, overlap/non-overlap is a run-time mode, and a qualifier input gates state advance. It sits on a serial bit stream and produces a registered match flag, with an optional saturating match counter, for downstream control logic.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..16; elaboration error outside that range.
PATTERN, 4'b1011, [PAT_LEN-1:0] target pattern; bit PAT_LEN-1 is received first.
CNT_W, 8, match counter width; legal range 1..32.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-low reset.
x  in  1  serial data bit.
z  in  1  advance qualifier; x is consumed only when z=1.
ovl  in  1  1 = overlapping detection, 0 = non-overlapping; sampled on every consumed bit.
cnt_clr  in  1  synchronous clear of match_cnt; present only with the option below.
y  out  1  Moore match flag; high exactly while state == PAT_LEN.
state_o  out  ST_W  current state = number of pattern bits matched. ST_W = $clog2(PAT_LEN+1).
match_cnt  out  CNT_W  saturating match count; present only with the option below.

Behaviour:
- Reset (rst=0, asynchronous): state=0, y=0, match_cnt=0. Outputs are held while rst=0. Release is synchronous to clk.
- States S0..S_PAT_LEN. Sk means the last k consumed bits equal PATTERN[PAT_LEN-1 : PAT_LEN-k].
- When z=0, state holds and y holds. A held match keeps y high.
- When z=1, x is consumed:
  - In Sk with k<PAT_LEN and x == PATTERN[PAT_LEN-1-k]: go to S(k+1).
  - On a mismatch: go to the failure target. This is the longest proper suffix of (matched prefix + x) that is also a prefix of PATTERN; it can be S0. This is KMP semantics and is computed at elaboration, with no run-time tables.
  - From S_PAT_LEN with ovl=1: treat as Sk where k is the longest proper border of PATTERN, then apply the rules above. This can re-enter S_PAT_LEN, e.g. PATTERN=1111.
  - From S_PAT_LEN with ovl=0: evaluate x as if from S0.
- y is registered together with state. It rises on the edge that consumes the final pattern bit, giving zero extra latency beyond the clock edge. It is never combinational from x.
- A mode change on ovl mid-stream affects only the transition out of S_PAT_LEN on the edge where ovl is sampled.
- Reset asserted mid-pattern aborts the partial match immediately. No match is reported for bits straddling reset.

Optional Feature:
Macro MOORE_SEQ_DET_CNT_EN.
- Defined: the cnt_clr and match_cnt ports exist.
  - match_cnt increments by 1 on every edge where next state is S_PAT_LEN and z=1. This includes S_PAT_LEN to S_PAT_LEN re-entry.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr=1 forces 0 on the next edge and wins over a simultaneous increment.
- Undefined: both ports are absent and the FSM behaviour is identical.

Decomposition:
- Package moore_seq_det_pkg holds:
  - Constant functions next_on_match(k), fail_target(k, bit, pattern, len) and border(pattern, len).
  - Parameter-range check helpers.
  - The ST_W localparam derivation.
- One sub-module, sat_counter (width CNT_W, inc, clr, count), instantiated only under MOORE_SEQ_DET_CNT_EN.
- The FSM stays in moore_seq_det as a single registered-state process plus a combinational next-state process.

Test Plan:
- Reset: rst=0 asserted mid-cycle with state=S3 -> state_o=0, y=0, match_cnt=0 immediately, without waiting for a clock edge.
- Overlap detection: PATTERN=1011, ovl=1, z=1, x=1,0,1,1,0,1,1 -> y=1 after bit 4 and after bit 7; state_o after bit 4 is 4 and after bit 5 is 2; match_cnt=2.
- Non-overlap detection: same stream with ovl=0 -> y=1 after bit 4 only; state_o after bit 7 is 1; match_cnt=1.
- Qualifier hold and failure target: x=1,0,1 with z=1, then 3 cycles of z=0 with x toggling -> state_o stays 3. Then x=0 with z=1 -> state_o=2 (failure target for "1010").
- Self-overlapping pattern: PATTERN=1111, ovl=1, six consecutive 1s -> y high for cycles 4-6 and match_cnt=3. The same stimulus with ovl=0 -> y high only at cycle 4.
- Counter saturation and clear: CNT_W=2, 5 matches -> match_cnt sticks at 3. cnt_clr=1 on the same edge as a match -> match_cnt=0.
